// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: writeback-source select codes
// and load funct3 codes.
package wb_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Picks the byte/half lane out of an aligned load word and sign- or
// zero-extends it; unknown funct3 codes fall back to the full word.
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      ofs,
  input  logic [2:0]      ld_type,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (ofs)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      default: byte_v = raw[31:24];
    endcase
    // Halfword lane is chosen by bit 1 only; a misaligned bit 0 is ignored.
    half_v = ofs[1] ? raw[31:16] : raw[15:0];

    case (ld_type)
      LD_B:    ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_BU:   ext = {{(XLEN-8){1'b0}}, byte_v};
      LD_H:    ext = {{(XLEN-16){half_v[15]}}, half_v};
      LD_HU:   ext = {{(XLEN-16){1'b0}}, half_v};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, once-only commit under
// stall, register-file write port, ID bypass, trace port and instret.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_valid_i,
  input  logic [XLEN-1:0]  mem_pc_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_rf_we_i,
  input  logic [1:0]       mem_wb_sel_i,
  input  logic [XLEN-1:0]  mem_alu_i,
  input  logic [XLEN-1:0]  mem_load_i,
  input  logic [2:0]       mem_ld_type_i,
  input  logic [XLEN-1:0]  mem_imm_i,
  output logic             we_reg,
  output logic [4:0]       wr,
  output logic [XLEN-1:0]  wd,
  output logic             fwd_valid_o,
  output logic [4:0]       fwd_rd_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic             debug_wb_have_inst,
  output logic [XLEN-1:0]  debug_wb_pc,
  output logic             debug_wb_ena,
  output logic [4:0]       debug_wb_reg,
  output logic [XLEN-1:0]  debug_wb_value,
  output logic [CNT_W-1:0] instret_o
);

  // Flow control: flush_i beats stall_i; stall_i holds every field. The
  // done bit remembers that the held instruction already committed so a
  // multi-cycle stall retires it exactly once.
  logic             valid_q;
  logic             done_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rd_q;
  logic             rf_we_q;
  logic [1:0]       wb_sel_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  load_q;
  logic [2:0]       ld_type_q;
  logic [XLEN-1:0]  imm_q;
  logic [CNT_W-1:0] instret_q;

  logic             commit;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  wb_val;

  assign commit = valid_q & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      wb_sel_q  <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      ld_type_q <= '0;
      imm_q     <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall_i) begin
      if (commit) done_q <= 1'b1;
    end else begin
      valid_q   <= mem_valid_i;
      done_q    <= 1'b0;
      pc_q      <= mem_pc_i;
      rd_q      <= mem_rd_i;
      rf_we_q   <= mem_rf_we_i;
      wb_sel_q  <= mem_wb_sel_i;
      alu_q     <= mem_alu_i;
      load_q    <= mem_load_i;
      ld_type_q <= mem_ld_type_i;
      imm_q     <= mem_imm_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (commit) instret_q <= instret_q + CNT_W'(1);
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .raw     (load_q),
    .ofs     (alu_q[1:0]),
    .ld_type (ld_type_q),
    .ext     (load_val)
  );

  always_comb begin
    wb_val = alu_q;
    case (wb_sel_q)
      WB_ALU:  wb_val = alu_q;
      WB_LOAD: wb_val = load_val;
      WB_PC4:  wb_val = pc_q + XLEN'(4);
      default: wb_val = imm_q;
    endcase
  end

  assign we_reg             = commit & rf_we_q & (rd_q != 5'd0);
  assign wr                 = rd_q;
  assign wd                 = wb_val;
  assign fwd_valid_o        = we_reg;
  assign fwd_rd_o           = rd_q;
  assign fwd_data_o         = wb_val;
  assign debug_wb_have_inst = commit;
  assign debug_wb_pc        = pc_q;
  assign debug_wb_ena       = we_reg;
  assign debug_wb_reg       = rd_q;
  assign debug_wb_value     = wb_val;
  assign instret_o          = instret_q;

endmodule
